multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the single-ALU register datapath (ADD/SUB/AND/OR/SLL/SRL, LoadImm).
//  Owns the PC and the instruction register. Fetches over a req/ack instruction port, then
//  decodes opcode/funct and drives load_imm/alu_ctrl/reg_write plus register addresses.
//  Sits between instruction memory and the register file / ALU.
// PARAMETERS
//  PC_W       32      PC / imem_addr width
//  RESET_PC   0       PC value after reset
//  ACK_TMO    15      max wait cycles for imem_ack before bus error (1..255)
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      async active-low reset
//  run         in   1      1 = execute instructions; sampled in IDLE and at end of WB
//  imem_req    out  1      fetch request, held until ack
//  imem_addr   out  PC_W   fetch address (=PC), stable while imem_req
//  imem_ack    in   1      fetch data valid this cycle
//  imem_rdata  in   32     instruction word
//  rs_addr     out  5      IR[25:21]
//  rt_addr     out  5      IR[20:16]
//  rd_addr     out  5      write reg: IR[15:11] R-type, IR[20:16] LoadImm
//  shamt       out  5      IR[10:6]
//  imm16       out  16     IR[15:0]
//  load_imm    out  1      1 = write-back source is zero-extended imm16
//  alu_ctrl    out  3      000 add,001 sub,010 and,011 or,100 sll,101 srl
//  reg_write   out  1      register-file write strobe, exactly 1 cycle per legal instr
//  busy        out  1      1 in any state except IDLE
//  illegal     out  1      sticky: undecodable instruction seen
//  bus_err     out  1      sticky: fetch timeout
//  instr_cnt   out  32     retired count (only with INSTR_COUNT_EN)
// BEHAVIOUR
//  Reset: state=IDLE, PC=RESET_PC, IR=0, all outputs 0; async assert, sync-safe release.
//  States: IDLE -> FETCH -> DECODE -> EXEC -> WB -> FETCH (run=1) | IDLE (run=0).
//  IDLE: busy=0; run=1 -> FETCH next cycle.
//  FETCH: imem_req=1, imem_addr=PC; at edge with imem_ack=1 latch IR<=imem_rdata, go DECODE.
//   wait counter clears on FETCH entry; ack absent ACK_TMO consecutive cycles -> bus_err=1,
//   imem_req drops, go IDLE, PC unchanged. ack outside FETCH ignored.
//  DECODE: opcode=IR[31:26], funct=IR[5:0].
//   opcode 00: funct 20h add,22h sub,24h and,25h or,00h sll,02h srl -> legal, load_imm=0.
//   opcode 3Fh: load_imm=1, alu_ctrl=000 (don't-care, driven 0).
//   anything else: illegal -> set illegal flag, go WB with reg_write suppressed.
//  EXEC: one cycle; rs/rt/rd/shamt/imm16/load_imm/alu_ctrl valid and stable from DECODE
//   exit through end of WB (registered from IR, no glitching).
//  WB: reg_write=1 for legal instr only; PC<=PC+4 (mod 2^PC_W, wraps to 0); retire.
//  Latency: 4 cycles/instr + fetch wait (ack in first FETCH cycle -> 4 cycles).
//  run dropped mid-instruction: current instr completes through WB, then IDLE.
//  rst_n low mid-operation: immediate return to reset state, no partial write strobe.
//  illegal/bus_err clear only on reset; neither stops execution except bus_err->IDLE.
//  rd_addr=0 still produces reg_write (register file owns r0 behaviour).
// CONFIGURATION
//  INSTR_COUNT_EN defined: instr_cnt increments by 1 in every WB (legal and illegal),
//   reset 0, wraps FFFF_FFFFh->0. Undefined: instr_cnt tied to 0, no counter flops.
// TESTING
//  T1 reset: rst_n=0 mid-EXEC -> all outputs 0, imem_addr=RESET_PC, busy=0 same cycle.
//  T2 add: run=1, ack immediate, rdata=0x00430820 (add r1,r2,r3) -> rs=2,rt=3,rd=1,
//     alu_ctrl=000, reg_write 1 cycle at cycle 4, next imem_addr=RESET_PC+4.
//  T3 LoadImm: rdata=0xFC05_1234 -> load_imm=1, rd_addr=5, imm16=1234h, reg_write pulse.
//  T4 all functs 20/22/24/25/00/02 back-to-back -> alu_ctrl 000..101, 6 pulses, 24 cycles.
//  T5 illegal: rdata=0x2000_0000 -> illegal=1, no reg_write, PC still +4, execution continues.
//  T6 timeout: ack held 0 for ACK_TMO cycles -> bus_err=1, state IDLE, PC unchanged;
//     INSTR_COUNT_EN build: instr_cnt equals number of WB cycles across T2-T5.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/decode/execute/write-back sequencer for the single-ALU register datapath.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module multicycle_ctrl #(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     ACK_TMO  = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [4:0]      rs_addr,
    output logic [4:0]      rt_addr,
    output logic [4:0]      rd_addr,
    output logic [4:0]      shamt,
    output logic [15:0]     imm16,
    output logic            load_imm,
    output logic [2:0]      alu_ctrl,
    output logic            reg_write,
    output logic            busy,
    output logic            illegal,
    output logic            bus_err,
    output logic [31:0]     instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TMO - 1);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [31:0]     ir;
    logic [7:0]      wait_cnt;
    logic            legal;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [3:0] rdec;
    logic       is_rtype;
    logic       is_limm;

    // Returns {legal, alu_ctrl} for an opcode-0 funct field.
    function automatic logic [3:0] decode_funct(input logic [5:0] f);
        case (f)
            6'h20:   return 4'b1_000;
            6'h22:   return 4'b1_001;
            6'h24:   return 4'b1_010;
            6'h25:   return 4'b1_011;
            6'h00:   return 4'b1_100;
            6'h02:   return 4'b1_101;
            default: return 4'b0_000;
        endcase
    endfunction

    assign opcode    = ir[31:26];
    assign funct     = ir[5:0];
    assign rdec      = decode_funct(funct);
    assign is_rtype  = (opcode == 6'h00) && rdec[3];
    assign is_limm   = (opcode == 6'h3F);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            wait_cnt  <= '0;
            legal     <= 1'b0;
            imem_req  <= 1'b0;
            rs_addr   <= '0;
            rt_addr   <= '0;
            rd_addr   <= '0;
            shamt     <= '0;
            imm16     <= '0;
            load_imm  <= 1'b0;
            alu_ctrl  <= '0;
            reg_write <= 1'b0;
            busy      <= 1'b0;
            illegal   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end else if (wait_cnt == TMO_LAST) begin
                        bus_err  <= 1'b1;
                        imem_req <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    // Fields are registered here and held until the next decode.
                    rs_addr <= ir[25:21];
                    rt_addr <= ir[20:16];
                    shamt   <= ir[10:6];
                    imm16   <= ir[15:0];
                    if (is_rtype) begin
                        rd_addr  <= ir[15:11];
                        load_imm <= 1'b0;
                        alu_ctrl <= rdec[2:0];
                        legal    <= 1'b1;
                        state    <= S_EXEC;
                    end else if (is_limm) begin
                        rd_addr  <= ir[20:16];
                        load_imm <= 1'b1;
                        alu_ctrl <= 3'b000;
                        legal    <= 1'b1;
                        state    <= S_EXEC;
                    end else begin
                        rd_addr  <= ir[15:11];
                        load_imm <= 1'b0;
                        alu_ctrl <= 3'b000;
                        legal    <= 1'b0;
                        illegal  <= 1'b1;
                        state    <= S_WB;
                    end
                end
                S_EXEC: begin
                    reg_write <= legal;
                    state     <= S_WB;
                end
                S_WB: begin
                    reg_write <= 1'b0;
                    pc        <= pc + PC_W'(4);
                    if (run) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    imem_req  <= 1'b0;
                    reg_write <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef INSTR_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= '0;
        end else if (state == S_WB) begin
            instr_cnt <= instr_cnt + 32'd1;
        end
    end
`else
    assign instr_cnt = '0;
`endif

endmodule
